cmp_latch_unit: RTL and testbench
=================================

Name: cmp_latch_unit

Overview:
- Parametrised successor of the 4-bit equality checker on the board I/O path.
- Captures two WIDTH-bit operands from a shared switch bus, using two push buttons.
- Each button is synchronised, debounced and edge-detected.
- A small FSM tracks which operands are loaded; the unit then drives a registered, mode-selectable comparison result (eq/ne/lt/gt) to an LED.

Parameters:
- WIDTH, 4, operand width in bits (>=1).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced button level changes (>=1).
- SIGNED_CMP, 0, 1 = lt/gt treat operands as two's complement; 0 = unsigned.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- no  input  WIDTH  operand switch bus, sampled on load pulses.
- push1  input  1  raw button, loads operand A.
- push2  input  1  raw button, loads operand B.
- clr  input  1  synchronous clear: both operands invalidated.
- mode  input  2  00 eq, 01 ne, 10 A<B, 11 A>B.
- a_valid  output  1  operand A held.
- b_valid  output  1  operand B held.
- result_valid  output  1  ledpin carries a valid comparison.
- ledpin  output  1  registered comparison result.

Behaviour:
- Reset (asynchronous, immediate, any state, including mid-debounce):
  - A and B registers = 0.
  - Sync flops, debounced levels and debounce counters = 0.
  - FSM = EMPTY.
  - a_valid, b_valid, result_valid and ledpin = 0.
- Button path, independent per button:
  - 2-flop synchroniser.
  - Debounce counter increments while the sync output differs from the debounced level; it resets to 0 whenever they agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A 0->1 transition of the debounced level gives exactly one load pulse; release produces nothing.
- Latency: raw push first sampled high at edge k and held → operand register loads at edge k+DEBOUNCE_CYCLES+3. ledpin/result_valid reflect it at edge k+DEBOUNCE_CYCLES+4.
- Glitches: any high pulse shorter than DEBOUNCE_CYCLES cycles (after sync) is ignored. Holding a button produces one load only.
- Load:
  - load1 → A <= no.
  - load2 → B <= no.
  - Both load pulses in the same cycle: push1 wins, load2 is dropped (button must be re-pressed).
- FSM states, one transition per cycle:
  - EMPTY: load1→HAVE_A, load2→HAVE_B.
  - HAVE_A: load2→READY; load1 reloads A and stays in HAVE_A.
  - HAVE_B: load1→READY; load2 reloads B and stays in HAVE_B.
  - READY: loads overwrite the respective operand and stay in READY.
  - clr in any state → EMPTY; operand values retained but invalid. clr takes priority over a same-cycle load.
- Valid flags:
  - a_valid = state in {HAVE_A, READY}.
  - b_valid = state in {HAVE_B, READY}.
- Result:
  - Registered each cycle from the current A, B, mode and state.
  - result_valid <= (state==READY).
  - ledpin <= result if READY, else 0.
- Comparison width rules:
  - Full-width compare over all WIDTH bits.
  - With SIGNED_CMP=1, the MSB is the sign bit.
- Mode change: takes effect on ledpin one cycle later, with no other side effect.

Test Plan:
- Reset, then press push1 with no=4'h9, then push2 with no=4'h9, mode=00 → a_valid, b_valid set; ledpin=1 and result_valid=1 exactly DEBOUNCE_CYCLES+4 edges after push2 is sampled.
- Bounce: push1 toggled high 3 cycles/low 2 cycles ×5, DEBOUNCE_CYCLES=4 → no load, a_valid stays 0; then held 10 cycles → exactly one load.
- A=4'h3, B=4'hC:
  - unsigned: mode 10 → ledpin=1, mode 11 → 0.
  - SIGNED_CMP=1 (B=-4): mode 10 → 0, mode 11 → 1.
  - mode 01 → 1 in both cases.
- push1 and push2 debounced edges coincide → A loads, B unchanged, FSM HAVE_A; then clr asserted together with a new load → EMPTY, all valid flags 0, ledpin 0 next cycle.
- WIDTH=8: A=8'hFF, B=8'hFE, mode 00 → ledpin=0. Reload B=8'hFF while READY → ledpin=1 one cycle after load.
- rst asserted mid-debounce and in READY → all outputs 0 immediately (asynchronously). A push continued after release of rst needs the full debounce latency again.

Source files
------------

// File: rtl/cmp_latch_unit.sv
// cmp_latch_unit: two-button operand capture with debounced loads and a
// registered, mode-selectable comparison result driven to an LED.
module cmp_latch_unit #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          SIGNED_CMP      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] no,
    input  logic             push1,
    input  logic             push2,
    input  logic             clr,
    input  logic [1:0]       mode,
    output logic             a_valid,
    output logic             b_valid,
    output logic             result_valid,
    output logic             ledpin
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {EMPTY, HAVE_A, HAVE_B, READY} state_t;

    // Button path, index 0 = push1, index 1 = push2
    logic [1:0]       raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       db_q, db_d, db_prev_q;
    logic [1:0]       load_q;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    // Operand, FSM and output registers
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic             rv_q, rv_d;
    logic             led_q, led_d;
    logic             eq_c, lt_c, gt_c, res_c;

    assign raw = {push2, push1};

    // Synchroniser, debounced level, edge history and registered load pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            load_q    <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            load_q    <= db_q & ~db_prev_q;
            for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Debounce: count cycles of disagreement, flip level after the full run
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // FSM, operand and output register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            a_q       <= '0;
            b_q       <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            rv_q      <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            rv_q      <= rv_d;
            led_q     <= led_d;
        end
    end

    // Comparison of the held operands
    always_comb begin
        eq_c = (a_q == b_q);
        if (SIGNED_CMP) begin
            lt_c = ($signed(a_q) < $signed(b_q));
            gt_c = ($signed(a_q) > $signed(b_q));
        end else begin
            lt_c = (a_q < b_q);
            gt_c = (a_q > b_q);
        end
        case (mode)
            2'b00:   res_c = eq_c;
            2'b01:   res_c = ~eq_c;
            2'b10:   res_c = lt_c;
            default: res_c = gt_c;
        endcase
    end

    // Next state: clr beats loads, load1 beats a same-cycle load2
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        if (clr) begin
            state_d = EMPTY;
        end else if (load_q[0]) begin
            a_d = no;
            case (state_q)
                EMPTY:   state_d = HAVE_A;
                HAVE_B:  state_d = READY;
                default: state_d = state_q;
            endcase
        end else if (load_q[1]) begin
            b_d = no;
            case (state_q)
                EMPTY:   state_d = HAVE_B;
                HAVE_A:  state_d = READY;
                default: state_d = state_q;
            endcase
        end
        a_valid_d = (state_d == HAVE_A) || (state_d == READY);
        b_valid_d = (state_d == HAVE_B) || (state_d == READY);
        rv_d      = (state_q == READY);
        led_d     = (state_q == READY) && res_c;
    end

    assign a_valid      = a_valid_q;
    assign b_valid      = b_valid_q;
    assign result_valid = rv_q;
    assign ledpin       = led_q;

endmodule

// File: tb/tb_cmp_latch_unit.sv
// Bench for cmp_latch_unit: three configurations driven by shared stimulus,
// checked every cycle against a behavioural model plus directed literals.
module tb_cmp_latch_unit;

    localparam int D = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       push1 = 1'b0;
    logic       push2 = 1'b0;
    logic       clr   = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic [7:0] no8   = 8'h00;

    logic [2:0] av, bv, rv, led;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // u0: 4-bit unsigned, u1: 4-bit signed, u2: 8-bit unsigned
    cmp_latch_unit #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .SIGNED_CMP(1'b0)) u0 (
        .clk(clk), .rst(rst), .no(no8[3:0]), .push1(push1), .push2(push2),
        .clr(clr), .mode(mode), .a_valid(av[0]), .b_valid(bv[0]),
        .result_valid(rv[0]), .ledpin(led[0]));
    cmp_latch_unit #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .SIGNED_CMP(1'b1)) u1 (
        .clk(clk), .rst(rst), .no(no8[3:0]), .push1(push1), .push2(push2),
        .clr(clr), .mode(mode), .a_valid(av[1]), .b_valid(bv[1]),
        .result_valid(rv[1]), .ledpin(led[1]));
    cmp_latch_unit #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .SIGNED_CMP(1'b0)) u2 (
        .clk(clk), .rst(rst), .no(no8), .push1(push1), .push2(push2),
        .clr(clr), .mode(mode), .a_valid(av[2]), .b_valid(bv[2]),
        .result_valid(rv[2]), .ledpin(led[2]));

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         w  [3] = '{4, 4, 8};
    bit         sg [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] m_a [3];
    logic [7:0] m_b [3];
    bit         m_ah, m_bh;
    bit         mdb   [2];
    int         since [2];
    int         ld_edge [2];
    bit         win [2][0:D+1];
    int         edge_n = 0;
    logic [2:0] e_av, e_bv, e_rv, e_led;

    function automatic logic [7:0] maskw(input logic [7:0] v, input int wd);
        if (wd >= 8) return v;
        return v & 8'((1 << wd) - 1);
    endfunction

    function automatic bit cmpf(input logic [7:0] a, input logic [7:0] b,
                                input logic [1:0] md, input int wd, input bit s);
        int va, vb;
        va = int'(a);
        vb = int'(b);
        if (s) begin
            if (a[wd-1]) va = va - (1 << wd);
            if (b[wd-1]) vb = vb - (1 << wd);
        end
        case (md)
            2'd0:    return va == vb;
            2'd1:    return va != vb;
            2'd2:    return va < vb;
            default: return va > vb;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_a[i] = 8'h00;
            m_b[i] = 8'h00;
        end
        m_ah = 1'b0;
        m_bh = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mdb[b]     = 1'b0;
            since[b]   = D;
            ld_edge[b] = -1;
            for (int j = 0; j < D + 2; j++) win[b][j] = 1'b0;
        end
        e_av = '0; e_bv = '0; e_rv = '0; e_led = '0;
    endtask

    // One rising edge: result from pre-edge operands, then loads, then buttons
    task automatic model_step();
        bit ready, ld1, ld2, alldiff;
        bit rawb [2];
        edge_n++;
        ready = m_ah && m_bh;
        for (int i = 0; i < 3; i++) begin
            e_rv[i]  = ready;
            e_led[i] = ready && cmpf(m_a[i], m_b[i], mode, w[i], sg[i]);
        end
        ld1 = (ld_edge[0] == edge_n);
        ld2 = (ld_edge[1] == edge_n) && !ld1;
        if (clr) begin
            m_ah = 1'b0;
            m_bh = 1'b0;
        end else if (ld1) begin
            for (int i = 0; i < 3; i++) m_a[i] = maskw(no8, w[i]);
            m_ah = 1'b1;
        end else if (ld2) begin
            for (int i = 0; i < 3; i++) m_b[i] = maskw(no8, w[i]);
            m_bh = 1'b1;
        end
        rawb[0] = push1;
        rawb[1] = push2;
        // A level is accepted once D consecutive samples, seen two edges late,
        // all disagree with it and none predate the last accepted change.
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < D + 1; j++) win[b][j] = win[b][j+1];
            win[b][D+1] = rawb[b];
            since[b]++;
            alldiff = 1'b1;
            for (int j = 0; j < D; j++) if (win[b][j] == mdb[b]) alldiff = 1'b0;
            if (since[b] >= D && alldiff) begin
                mdb[b]   = ~mdb[b];
                since[b] = 0;
                if (mdb[b]) ld_edge[b] = edge_n + 2;
            end
        end
        e_av = {3{m_ah}};
        e_bv = {3{m_bh}};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Cycle compare away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("cyc_a_valid[u%0d]", i), 8'(av[i]), 8'(e_av[i]));
                chk($sformatf("cyc_b_valid[u%0d]", i), 8'(bv[i]), 8'(e_bv[i]));
                chk($sformatf("cyc_result_valid[u%0d]", i), 8'(rv[i]), 8'(e_rv[i]));
                chk($sformatf("cyc_ledpin[u%0d]", i), 8'(led[i]), 8'(e_led[i]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int btn, input int hold);
        if (btn == 1) push1 = 1'b1; else push2 = 1'b1;
        tick(hold);
        push1 = 1'b0;
        push2 = 1'b0;
        tick(D + 5);
    endtask

    initial begin
        #1 rst = 1'b1;
        tick(3);
        chk("rst_a_valid", 8'(av), 8'h0);
        chk("rst_b_valid", 8'(bv), 8'h0);
        chk("rst_result_valid", 8'(rv), 8'h0);
        chk("rst_ledpin", 8'(led), 8'h0);
        rst = 1'b0;
        tick(2);

        // equal operands 9/9, with exact push2 latency
        no8 = 8'h09;
        press(1, 8);
        chk("t1_a_valid", 8'(av[0]), 8'h1);
        chk("t1_b_valid", 8'(bv[0]), 8'h0);
        push2 = 1'b1;
        tick(D + 4);
        chk("t1_b_loaded", 8'(bv[0]), 8'h1);
        chk("t1_rv_not_yet", 8'(rv[0]), 8'h0);
        tick(1);
        chk("t1_rv", 8'(rv), 8'h7);
        chk("t1_led", 8'(led), 8'h7);
        chk("t1_model_led", 8'(e_led), 8'h7);
        push2 = 1'b0;
        tick(D + 5);

        // bounce rejection, then a single long hold
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_a_valid", 8'(av), 8'h0);
        no8 = 8'h03;
        repeat (5) begin
            push1 = 1'b1; tick(3);
            push1 = 1'b0; tick(2);
        end
        tick(6);
        chk("bounce_no_load", 8'(av[0]), 8'h0);
        push1 = 1'b1;
        tick(D + 4);
        chk("hold_loaded", 8'(av[0]), 8'h1);
        no8 = 8'h0E;
        tick(6);
        push1 = 1'b0;
        tick(D + 5);
        no8 = 8'h0C;
        press(2, 8);
        mode = 2'b10;
        tick(1);
        chk("lt_unsigned", 8'(led[0]), 8'h1);
        chk("lt_signed", 8'(led[1]), 8'h0);
        chk("lt_w8", 8'(led[2]), 8'h1);
        mode = 2'b11;
        tick(1);
        chk("gt_unsigned", 8'(led[0]), 8'h0);
        chk("gt_signed", 8'(led[1]), 8'h1);
        mode = 2'b01;
        tick(1);
        chk("ne_both", 8'(led), 8'h7);

        // coincident presses, then clr colliding with a load
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        no8 = 8'h05;
        push1 = 1'b1;
        push2 = 1'b1;
        tick(8);
        push1 = 1'b0;
        push2 = 1'b0;
        tick(D + 5);
        chk("coin_a_valid", 8'(av), 8'h7);
        chk("coin_b_valid", 8'(bv), 8'h0);
        no8 = 8'h07;
        push2 = 1'b1;
        tick(D + 3);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clrload_a_valid", 8'(av), 8'h0);
        chk("clrload_b_valid", 8'(bv), 8'h0);
        tick(1);
        chk("clrload_led", 8'(led), 8'h0);
        push2 = 1'b0;
        tick(D + 5);
        chk("clrload_stays_empty", 8'(bv), 8'h0);

        // 8-bit FF vs FE, then reload B while READY
        mode = 2'b00;
        no8 = 8'hFF;
        press(1, 8);
        no8 = 8'hFE;
        press(2, 8);
        chk("w8_ne_led", 8'(led[2]), 8'h0);
        chk("w8_rv", 8'(rv[2]), 8'h1);
        no8 = 8'hFF;
        push2 = 1'b1;
        tick(D + 4);
        chk("w8_reload_edge_led", 8'(led[2]), 8'h0);
        tick(1);
        chk("w8_reload_led", 8'(led[2]), 8'h1);
        push2 = 1'b0;
        tick(D + 5);

        // async reset in READY and mid-debounce
        push1 = 1'b1;
        tick(3);
        #1 rst = 1'b1;
        #1;
        chk("arst_a_valid", 8'(av), 8'h0);
        chk("arst_b_valid", 8'(bv), 8'h0);
        chk("arst_rv", 8'(rv), 8'h0);
        chk("arst_led", 8'(led), 8'h0);
        tick(2);
        rst = 1'b0;
        tick(D + 3);
        chk("post_rst_not_yet", 8'(av[0]), 8'h0);
        tick(1);
        chk("post_rst_loaded", 8'(av[0]), 8'h1);
        push1 = 1'b0;
        tick(D + 5);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
